// File: rtl/xg_frame_checker.sv
// Receive-side XGMII test-frame checker: parses generator frames, verifies header,
// length, sequence and payload pattern, and keeps saturating counters for software.
module xg_frame_checker #(
    parameter int          MAX_WORDS = 1024,
    parameter logic [15:0] MAGIC     = 16'h5847
) (
    input  logic        clk156,
    input  logic        resetn,
    input  logic [63:0] xgmii_rxd,
    input  logic [7:0]  xgmii_rxc,
    input  logic        clear,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        locked,
    output logic [31:0] good_frames,
    output logic [31:0] bad_frames,
    output logic [31:0] seq_errors,
    output logic [31:0] word_errors
);

    localparam logic [63:0] START_D = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] TERM_D  = 64'h0707_0707_0707_07FD;
    localparam logic [63:0] IDLE_D  = 64'h0707_0707_0707_0707;
    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_DROP} state_t;

    state_t      r_state;
    logic [63:0] r_rxd;
    logic [7:0]  r_rxc;
    logic [15:0] r_len;
    logic [15:0] r_idx;
    logic [31:0] r_exp;
    logic [31:0] r_last_seq;
    logic        r_sync;
    logic        r_bad;

    logic        w_start, w_term, w_idle, w_ctl;
    logic [15:0] w_len;
    logic [31:0] w_seq;
    logic        w_hdr_bad, w_in_len, w_word_mis;
    logic        w_end, w_good, w_hdr_ok, w_seq_err, w_word_err;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        w_start    = (r_rxc == 8'h01) && (r_rxd == START_D);
        w_term     = (r_rxc == 8'hFF) && (r_rxd == TERM_D);
        w_idle     = (r_rxc == 8'hFF) && (r_rxd == IDLE_D);
        w_ctl      = |r_rxc;
        w_len      = r_rxd[31:16];
        w_seq      = r_rxd[63:32];
        w_hdr_bad  = (r_rxd[15:0] != MAGIC) || (w_len < 16'd2) || (w_len > MAX_LEN);
        w_in_len   = r_idx < r_len;
        w_word_mis = r_rxd != {r_exp, r_exp};
    end

    // Per-word events; counters and outputs below are driven only from these.
    always_comb begin
        w_end      = 1'b0;
        w_good     = 1'b0;
        w_hdr_ok   = 1'b0;
        w_seq_err  = 1'b0;
        w_word_err = 1'b0;
        case (r_state)
            S_HDR: begin
                if (w_start || w_ctl || w_hdr_bad) begin
                    w_end = 1'b1;
                end else begin
                    w_hdr_ok  = 1'b1;
                    w_seq_err = r_sync && (w_seq != r_last_seq + 32'd1);
                end
            end
            S_DATA: begin
                if (!w_ctl) begin
                    if (w_in_len) w_word_err = w_word_mis;
                    else          w_end      = 1'b1;
                end else begin
                    w_end  = 1'b1;
                    w_good = w_term && (r_idx == r_len) && !r_bad;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk156 or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_rxd       <= '0;
            r_rxc       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_exp       <= '0;
            r_last_seq  <= '0;
            r_sync      <= 1'b0;
            r_bad       <= 1'b0;
            frame_done  <= 1'b0;
            frame_ok    <= 1'b0;
            locked      <= 1'b0;
            good_frames <= '0;
            bad_frames  <= '0;
            seq_errors  <= '0;
            word_errors <= '0;
        end else begin
            r_rxd      <= xgmii_rxd;
            r_rxc      <= xgmii_rxc;
            frame_done <= w_end;
            frame_ok   <= w_good;

            case (r_state)
                S_IDLE: if (w_start) r_state <= S_HDR;
                S_HDR: begin
                    if (w_start)        r_state <= S_HDR;
                    else if (w_ctl)     r_state <= S_IDLE;
                    else if (w_hdr_bad) r_state <= S_DROP;
                    else begin
                        r_len   <= w_len;
                        r_idx   <= 16'd1;
                        r_exp   <= w_seq + 32'd1;
                        r_bad   <= 1'b0;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!w_ctl) begin
                        if (w_in_len) begin
                            r_idx <= r_idx + 16'd1;
                            r_exp <= r_exp + 32'd1;
                            if (w_word_mis) r_bad <= 1'b1;
                        end else begin
                            r_state <= S_DROP;
                        end
                    end else if (w_term)  r_state <= S_IDLE;
                    else if (w_start)     r_state <= S_HDR;
                    else                  r_state <= S_DROP;
                end
                S_DROP: begin
                    if (w_term || w_idle) r_state <= S_IDLE;
                    else if (w_start)     r_state <= S_HDR;
                end
                default: r_state <= S_IDLE;
            endcase

            // clear wins over any same-cycle event, including sequence resync.
            if (clear) begin
                locked      <= 1'b0;
                r_sync      <= 1'b0;
                good_frames <= '0;
                bad_frames  <= '0;
                seq_errors  <= '0;
                word_errors <= '0;
            end else begin
                if (w_end && w_good) begin
                    good_frames <= sat_inc(good_frames);
                    locked      <= 1'b1;
                end
                if (w_end && !w_good) bad_frames  <= sat_inc(bad_frames);
                if (w_seq_err)        seq_errors  <= sat_inc(seq_errors);
                if (w_word_err)       word_errors <= sat_inc(word_errors);
                if (w_hdr_ok) begin
                    r_last_seq <= w_seq;
                    r_sync     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_xg_frame_checker.sv
// Scoreboard bench for xg_frame_checker: expected frame results are queued before
// each frame is driven and compared when frame_done fires.
module tb_xg_frame_checker;

    localparam int MAXW = 1024;
    localparam logic [63:0] START_D = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] TERM_D  = 64'h0707_0707_0707_07FD;
    localparam logic [63:0] IDLE_D  = 64'h0707_0707_0707_0707;

    logic        clk156 = 1'b0;
    logic        resetn;
    logic [63:0] xgmii_rxd;
    logic [7:0]  xgmii_rxc;
    logic        clear;
    logic        frame_done, frame_ok, locked;
    logic [31:0] good_frames, bad_frames, seq_errors, word_errors;

    xg_frame_checker #(.MAX_WORDS(MAXW), .MAGIC(16'h5847)) dut (
        .clk156(clk156), .resetn(resetn), .xgmii_rxd(xgmii_rxd), .xgmii_rxc(xgmii_rxc),
        .clear(clear), .frame_done(frame_done), .frame_ok(frame_ok), .locked(locked),
        .good_frames(good_frames), .bad_frames(bad_frames),
        .seq_errors(seq_errors), .word_errors(word_errors)
    );

    always #5 clk156 = ~clk156;

    typedef struct {
        logic        ok;
        logic [31:0] good, bad, seq, word;
        logic        lck;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] m_good, m_bad, m_seq, m_word;
    logic        m_lck;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] sinc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic void m_zero();
        m_good = 0; m_bad = 0; m_seq = 0; m_word = 0; m_lck = 1'b0;
    endfunction

    // Advance the model by one frame and queue the expected frame_done result.
    function automatic void exp_frame(input bit ok, input bit seq_err, input int word_errs);
        exp_t e;
        if (ok) begin m_good = sinc(m_good); m_lck = 1'b1; end
        else    m_bad = sinc(m_bad);
        if (seq_err) m_seq = sinc(m_seq);
        for (int i = 0; i < word_errs; i++) m_word = sinc(m_word);
        e.ok = ok; e.good = m_good; e.bad = m_bad; e.seq = m_seq; e.word = m_word; e.lck = m_lck;
        q.push_back(e);
    endfunction

    always @(negedge clk156) begin : mon
        exp_t e;
        if (resetn && frame_done) begin
            if (q.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("frame_ok", {31'd0, frame_ok}, {31'd0, e.ok});
                chk("good_frames", good_frames, e.good);
                chk("bad_frames", bad_frames, e.bad);
                chk("seq_errors", seq_errors, e.seq);
                chk("word_errors", word_errors, e.word);
                chk("locked", {31'd0, locked}, {31'd0, e.lck});
            end
        end
    end

    task automatic drv(input logic [63:0] d, input logic [7:0] c);
        @(negedge clk156);
        xgmii_rxd = d;
        xgmii_rxc = c;
    endtask

    task automatic send_frame(input logic [31:0] seq, input logic [15:0] len, input logic [15:0] magic,
                              input int ndata, input int flip, input bit term);
        logic [31:0] w;
        logic [63:0] d;
        drv(START_D, 8'h01);
        drv({seq, len, magic}, 8'h00);
        for (int i = 1; i <= ndata; i++) begin
            w = seq + 32'(i);
            d = {w, w};
            if (i == flip) d[0] = ~d[0];
            drv(d, 8'h00);
        end
        if (term) drv(TERM_D, 8'hFF);
    endtask

    task automatic drain();
        int n = 0;
        drv(IDLE_D, 8'hFF);
        while (q.size() != 0 && n < 40) begin
            drv(IDLE_D, 8'hFF);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 32'd0);
            q.delete();
        end
        repeat (3) drv(IDLE_D, 8'hFF);
    endtask

    task automatic do_clear();
        @(negedge clk156); clear = 1'b1;
        @(negedge clk156); clear = 1'b0;
        m_zero();
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_good"}, good_frames, m_good);
        chk({tag, "_bad"}, bad_frames, m_bad);
        chk({tag, "_seq"}, seq_errors, m_seq);
        chk({tag, "_word"}, word_errors, m_word);
        chk({tag, "_locked"}, {31'd0, locked}, {31'd0, m_lck});
    endtask

    initial begin
        resetn = 1'b0; clear = 1'b0; xgmii_rxd = IDLE_D; xgmii_rxc = 8'hFF;
        m_zero();
        repeat (3) @(negedge clk156);
        chk("rst_done", {31'd0, frame_done}, 32'd0);
        chk("rst_ok", {31'd0, frame_ok}, 32'd0);
        chk_counters("rst");
        resetn = 1'b1;
        repeat (2) drv(IDLE_D, 8'hFF);

        // Three clean back-to-back frames.
        exp_frame(1, 0, 0); exp_frame(1, 0, 0); exp_frame(1, 0, 0);
        send_frame(10, 4, 16'h5847, 3, 0, 1);
        send_frame(11, 4, 16'h5847, 3, 0, 1);
        send_frame(12, 4, 16'h5847, 3, 0, 1);
        drain();
        chk_counters("good3");

        // Single-bit payload error in data word 3.
        exp_frame(0, 0, 1);
        send_frame(13, 8, 16'h5847, 7, 3, 1);
        drain();

        // Sequence gap 5 -> 7; both frames still good.
        do_clear();
        chk("clear_locked", {31'd0, locked}, 32'd0);
        exp_frame(1, 0, 0); exp_frame(1, 1, 0);
        send_frame(5, 4, 16'h5847, 3, 0, 1);
        send_frame(7, 4, 16'h5847, 3, 0, 1);
        drain();

        // Length and magic checks, then a maximum-length good frame.
        do_clear();
        exp_frame(0, 0, 0); exp_frame(0, 0, 0); exp_frame(0, 0, 0);
        exp_frame(0, 0, 0); exp_frame(0, 0, 0); exp_frame(1, 0, 0);
        send_frame(100, 4, 16'h5847, 2, 0, 1);
        send_frame(101, 4, 16'h5847, 5, 0, 1);
        send_frame(500, 16'(MAXW + 1), 16'h5847, 3, 0, 1);
        send_frame(600, 4, 16'h0000, 3, 0, 1);
        send_frame(700, 1, 16'h5847, 0, 0, 1);
        send_frame(102, 16'(MAXW), 16'h5847, MAXW - 1, 0, 1);
        drain();
        chk_counters("len");

        // Restart from DATA and from HDR; the following frames are good.
        do_clear();
        exp_frame(0, 0, 0); exp_frame(1, 0, 0); exp_frame(0, 0, 0); exp_frame(1, 0, 0);
        send_frame(200, 6, 16'h5847, 2, 0, 0);
        send_frame(201, 4, 16'h5847, 3, 0, 1);
        drv(START_D, 8'h01);
        send_frame(202, 4, 16'h5847, 3, 0, 1);
        drain();

        // Reset mid-frame: no frame_done, counters cleared.
        drv(START_D, 8'h01);
        drv({32'd300, 16'd8, 16'h5847}, 8'h00);
        drv({32'd301, 32'd301}, 8'h00);
        drv({32'd302, 32'd302}, 8'h00);
        @(negedge clk156);
        resetn = 1'b0; xgmii_rxd = IDLE_D; xgmii_rxc = 8'hFF;
        m_zero();
        repeat (2) @(negedge clk156);
        resetn = 1'b1;
        repeat (4) drv(IDLE_D, 8'hFF);
        chk_counters("midrst");
        chk("midrst_q", q.size(), 32'd0);

        // Saturation of good_frames.
        do_clear();
        @(negedge clk156);
        dut.good_frames = 32'hFFFF_FFFE;
        m_good = 32'hFFFF_FFFE;
        exp_frame(1, 0, 0); exp_frame(1, 0, 0);
        send_frame(400, 4, 16'h5847, 3, 0, 1);
        send_frame(401, 4, 16'h5847, 3, 0, 1);
        drain();
        chk("sat_hold", good_frames, 32'hFFFF_FFFF);

        // clear on the same edge as frame_done: counters and locked end at 0.
        begin
            exp_t e;
            e.ok = 1'b1; e.good = 0; e.bad = 0; e.seq = 0; e.word = 0; e.lck = 1'b0;
            q.push_back(e);
        end
        send_frame(402, 4, 16'h5847, 3, 0, 1);
        @(negedge clk156);
        xgmii_rxd = IDLE_D; xgmii_rxc = 8'hFF; clear = 1'b1;
        @(negedge clk156);
        clear = 1'b0;
        m_zero();
        drain();
        chk_counters("clr_done");

        chk("q_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
